// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter whose state lives in T flip-flops; each
// bit toggles only when it must change on the next clock edge.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (q=0, wrap=0)
//   en   - count enable
//   up   - direction, 1 = increment, 0 = decrement
//   load - synchronous parallel load of d (out-of-range d loads 0)
//   d    - load value
//   q    - current count (T flip-flop outputs)
//   tc   - combinational terminal count, feeds the next digit's en
//   wrap - registered one-cycle pulse after a wrap-around edge
module tff_mod_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // MODULO may equal 2^WIDTH, so the load range check needs one
  // extra bit; the terminal value always fits in WIDTH bits.
  localparam logic [WIDTH:0]   MOD_L = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;
  logic             oor;

  assign at_max  = (q_q == MAX_L);
  assign at_zero = (q_q == '0);
  assign oor     = (q_q > MAX_L);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = ({1'b0, d} < MOD_L) ? d : '0;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else if (oor) begin
          // fault recovery, deliberately silent
          q_d = '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_L;
          wrap_d = 1'b1;
        end else if (oor) begin
          q_d = MAX_L;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  // Toggle vector: a bit's T input is high only where it must flip.
  assign t_d = q_q ^ q_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_q ^ t_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule
